memory_access_cycle: RTL and testbench

- Memory stage of the 5-stage RISC-V pipeline. Takes execute-stage results, runs loads/stores over a req/ready data-memory bus, stalls the pipeline on wait states, and formats load data.
- Registers everything the writeback stage consumes: ResultSrcW, ALU_ResultW, ReadDataW, PCPlus4W, plus RegWriteW/RDW for the register file.
- Produces the ReadDataW that writeback selects between.

---
 rtl/memory_access_cycle_pkg.sv | 49 ++++
 rtl/memory_access_cycle_load_align.sv | 35 +++
 rtl/memory_access_cycle.sv | 165 ++++++++++++++++
 tb/tb_memory_access_cycle.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_cycle_pkg.sv
// Shared definitions for the memory stage: access encodings, FSM states,
// datapath widths and the access-legality rule used by the stage.
package memory_access_cycle_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // Load encodings (funct3)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store encodings (funct3)
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Bus FSM states
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // An access is legal when funct3 names a supported size for its
    // direction and the address is naturally aligned for that size.
    function automatic logic access_legal(input logic       is_store,
                                          input logic [2:0] f3,
                                          input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        if (is_store) begin
            case (f3)
                F3_SB:   ok = 1'b1;
                F3_SH:   ok = ~addr_lo[0];
                F3_SW:   ok = (addr_lo == 2'b00);
                default: ok = 1'b0;
            endcase
        end else begin
            case (f3)
                F3_LB, F3_LBU: ok = 1'b1;
                F3_LH, F3_LHU: ok = ~addr_lo[0];
                F3_LW:         ok = (addr_lo == 2'b00);
                default:       ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/memory_access_cycle_load_align.sv
// Load data alignment: picks the addressed byte/halfword out of the bus
// word and sign- or zero-extends it according to funct3.
module memory_access_cycle_load_align
    import memory_access_cycle_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Lane selection and extension of the returned word
    always_comb begin
        case (addr_lo)
            2'd0:    sel_byte = rdata[7:0];
            2'd1:    sel_byte = rdata[15:8];
            2'd2:    sel_byte = rdata[23:16];
            default: sel_byte = rdata[31:24];
        endcase
        sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_LB:   data = {{24{sel_byte[7]}}, sel_byte};
            F3_LH:   data = {{16{sel_half[15]}}, sel_half};
            F3_LW:   data = rdata;
            F3_LBU:  data = {24'd0, sel_byte};
            F3_LHU:  data = {16'd0, sel_half};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/memory_access_cycle.sv
// Memory stage of the 5-stage RISC-V pipeline. Issues loads/stores on a
// req/ready data bus, stalls upstream during wait states, aborts on a
// wait-state timeout, and registers everything writeback consumes.
module memory_access_cycle
    import memory_access_cycle_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ValidM,
    input  logic                  RegWriteM,
    input  logic                  MemWriteM,
    input  logic                  ResultSrcM,
    input  logic [2:0]            funct3M,
    input  logic [REG_ADDR_W-1:0] RDM,
    input  logic [XLEN-1:0]       ALU_ResultM,
    input  logic [XLEN-1:0]       WriteDataM,
    input  logic [XLEN-1:0]       PCPlus4M,
    output logic                  StallM,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [XLEN-1:0]       dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [XLEN-1:0]       dmem_wdata,
    input  logic                  dmem_ready,
    input  logic [XLEN-1:0]       dmem_rdata,
    output logic                  ValidW,
    output logic                  RegWriteW,
    output logic                  ResultSrcW,
    output logic [REG_ADDR_W-1:0] RDW,
    output logic [XLEN-1:0]       ALU_ResultW,
    output logic [XLEN-1:0]       ReadDataW,
    output logic [XLEN-1:0]       PCPlus4W,
    output logic                  ExceptW,
    output logic                  BusErrW
);

    // Wait counter is sized to hold TIMEOUT_CYC; with the timeout disabled
    // it is a single unused bit.
    localparam int              CNT_W   = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [0:0]       state;
    logic [CNT_W-1:0] wait_cnt;

    logic             mem_op;
    logic             legal;
    logic             mem_legal;
    logic             mem_illegal;
    logic             is_load;
    logic             timeout_abort;
    logic [XLEN-1:0]  load_data;

    assign mem_op      = ValidM & (MemWriteM | ResultSrcM);
    assign is_load     = ResultSrcM & ~MemWriteM;
    assign legal       = access_legal(MemWriteM, funct3M, ALU_ResultM[1:0]);
    assign mem_legal   = mem_op & legal;
    assign mem_illegal = mem_op & ~legal;

    // Abort fires on the cycle the counter has reached the limit and the
    // bus still has not answered; a late ready on that cycle still wins.
    assign timeout_abort = (TIMEOUT_CYC != 0) && (state == ST_WAIT) &&
                           !dmem_ready && (wait_cnt == CNT_LIM);

    // Reset gates the request combinationally so it drops the moment rst
    // asserts, not at the next clock.
    assign dmem_req  = rst & mem_legal & ~timeout_abort;
    assign StallM    = rst & mem_legal & ~dmem_ready & ~timeout_abort;
    assign dmem_we   = dmem_req & MemWriteM;
    assign dmem_addr = {ALU_ResultM[XLEN-1:2], 2'b00};

    // Store lane replication and byte enables, derived from access size
    always_comb begin
        case (funct3M[1:0])
            2'b00: begin
                dmem_be    = 4'b0001 << ALU_ResultM[1:0];
                dmem_wdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                dmem_be    = 4'b0011 << {ALU_ResultM[1], 1'b0};
                dmem_wdata = {2{WriteDataM[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = WriteDataM;
            end
        endcase
    end

    memory_access_cycle_load_align u_load_align (
        .rdata   (dmem_rdata),
        .addr_lo (ALU_ResultM[1:0]),
        .funct3  (funct3M),
        .data    (load_data)
    );

    // Bus FSM: tracks outstanding requests and counts wait states
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_legal && !dmem_ready) begin
                        state    <= ST_WAIT;
                        wait_cnt <= CNT_ONE;
                    end
                end
                default: begin
                    if (dmem_ready || timeout_abort || !mem_legal) begin
                        state    <= ST_IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt != CNT_LIM) begin
                        wait_cnt <= wait_cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

    // ---- M -> W pipeline boundary ----
    // Writeback register: bubble while stalled or empty, else capture M
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ValidW      <= 1'b0;
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 1'b0;
            RDW         <= '0;
            ALU_ResultW <= '0;
            ReadDataW   <= '0;
            PCPlus4W    <= '0;
            ExceptW     <= 1'b0;
            BusErrW     <= 1'b0;
        end else if (StallM) begin
            ValidW    <= 1'b0;
            RegWriteW <= 1'b0;
            ExceptW   <= 1'b0;
            BusErrW   <= 1'b0;
        end else if (!ValidM) begin
            ValidW      <= 1'b0;
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 1'b0;
            RDW         <= '0;
            ALU_ResultW <= '0;
            ReadDataW   <= '0;
            PCPlus4W    <= '0;
            ExceptW     <= 1'b0;
            BusErrW     <= 1'b0;
        end else begin
            ValidW      <= 1'b1;
            RegWriteW   <= RegWriteM & ~mem_illegal & ~timeout_abort;
            ResultSrcW  <= ResultSrcM;
            RDW         <= RDM;
            ALU_ResultW <= ALU_ResultM;
            ReadDataW   <= (is_load && legal && !timeout_abort) ? load_data : '0;
            PCPlus4W    <= PCPlus4M;
            ExceptW     <= mem_illegal;
            BusErrW     <= timeout_abort;
        end
    end

endmodule

// File: tb/tb_memory_access_cycle.sv
// Directed bench for the memory stage: zero-wait and wait-state loads,
// load formatting, store lanes, misalignment, timeout and async reset.
module tb_memory_access_cycle;

    logic        clk;
    logic        rst;
    logic        ValidM, RegWriteM, MemWriteM, ResultSrcM;
    logic [2:0]  funct3M;
    logic [4:0]  RDM;
    logic [31:0] ALU_ResultM, WriteDataM, PCPlus4M;
    logic        StallM, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        ValidW, RegWriteW, ResultSrcW;
    logic [4:0]  RDW;
    logic [31:0] ALU_ResultW, ReadDataW, PCPlus4W;
    logic        ExceptW, BusErrW;

    int n_checks = 0;
    int n_fail   = 0;

    memory_access_cycle #(.TIMEOUT_CYC(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .ValidM      (ValidM),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .ResultSrcM  (ResultSrcM),
        .funct3M     (funct3M),
        .RDM         (RDM),
        .ALU_ResultM (ALU_ResultM),
        .WriteDataM  (WriteDataM),
        .PCPlus4M    (PCPlus4M),
        .StallM      (StallM),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_ready  (dmem_ready),
        .dmem_rdata  (dmem_rdata),
        .ValidW      (ValidW),
        .RegWriteW   (RegWriteW),
        .ResultSrcW  (ResultSrcW),
        .RDW         (RDW),
        .ALU_ResultW (ALU_ResultW),
        .ReadDataW   (ReadDataW),
        .PCPlus4W    (PCPlus4W),
        .ExceptW     (ExceptW),
        .BusErrW     (BusErrW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic mw, input logic rs,
                         input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc);
        ValidM      = v;
        RegWriteM   = rw;
        MemWriteM   = mw;
        ResultSrcM  = rs;
        funct3M     = f3;
        RDM         = rd;
        ALU_ResultM = alu;
        WriteDataM  = wd;
        PCPlus4M    = pc;
    endtask

    // Advance to just after the next active edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;

        // Reset state
        step();
        check("rst_req",    {31'd0, dmem_req}, 32'h0);
        check("rst_stall",  {31'd0, StallM},   32'h0);
        check("rst_validw", {31'd0, ValidW},   32'h0);
        check("rst_aluw",   ALU_ResultW,       32'h0);
        check("rst_rdw",    ReadDataW,         32'h0);
        rst = 1'b1;

        // LW 0x100, zero wait
        drive(1, 1, 0, 1, 3'b010, 5'd1, 32'h100, 32'h0, 32'h4);
        dmem_ready = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        #3;
        check("lw_stall", {31'd0, StallM},   32'h0);
        check("lw_req",   {31'd0, dmem_req}, 32'h1);
        check("lw_we",    {31'd0, dmem_we},  32'h0);
        check("lw_addr",  dmem_addr,         32'h100);
        check("lw_be",    {28'd0, dmem_be},  32'hF);
        step();
        check("lw_data",  ReadDataW,           32'hDEADBEEF);
        check("lw_regw",  {31'd0, RegWriteW},  32'h1);
        check("lw_rsrc",  {31'd0, ResultSrcW}, 32'h1);
        check("lw_valid", {31'd0, ValidW},     32'h1);
        check("lw_rd",    {27'd0, RDW},        32'h1);
        check("lw_pc4",   PCPlus4W,            32'h4);

        // LB 0x103 with three wait states
        drive(1, 1, 0, 1, 3'b000, 5'd2, 32'h103, 32'h0, 32'h8);
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #3;
            check("lb_wait_stall", {31'd0, StallM},   32'h1);
            check("lb_wait_req",   {31'd0, dmem_req}, 32'h1);
            check("lb_wait_addr",  dmem_addr,         32'h100);
            step();
            check("lb_wait_bubble", {30'd0, ValidW, RegWriteW}, 32'h0);
        end
        dmem_ready = 1'b1;
        dmem_rdata = 32'h80FFFF7F;
        #3;
        check("lb_done_stall", {31'd0, StallM}, 32'h0);
        step();
        check("lb_data",  ReadDataW,          32'hFFFFFF80);
        check("lb_regw",  {31'd0, RegWriteW}, 32'h1);
        check("lb_rd",    {27'd0, RDW},       32'h2);

        // LBU / LH / LHU formatting, zero wait
        drive(1, 1, 0, 1, 3'b100, 5'd3, 32'h103, 32'h0, 32'hC);
        step();
        check("lbu_data", ReadDataW, 32'h00000080);
        drive(1, 1, 0, 1, 3'b001, 5'd3, 32'h102, 32'h0, 32'hC);
        step();
        check("lh_data", ReadDataW, 32'hFFFF80FF);
        drive(1, 1, 0, 1, 3'b101, 5'd3, 32'h100, 32'h0, 32'hC);
        step();
        check("lhu_data", ReadDataW, 32'h0000FF7F);

        // SH 0x202 with two wait states; request fields held stable
        drive(1, 0, 1, 0, 3'b001, 5'd0, 32'h202, 32'h1234ABCD, 32'h10);
        dmem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #3;
            check("sh_stall", {31'd0, StallM},   32'h1);
            check("sh_req",   {31'd0, dmem_req}, 32'h1);
            check("sh_we",    {31'd0, dmem_we},  32'h1);
            check("sh_addr",  dmem_addr,         32'h200);
            check("sh_be",    {28'd0, dmem_be},  32'hC);
            check("sh_wdata", dmem_wdata,        32'hABCDABCD);
            step();
        end
        dmem_ready = 1'b1;
        step();
        check("sh_valid", {31'd0, ValidW},     32'h1);
        check("sh_regw",  {31'd0, RegWriteW},  32'h0);
        check("sh_rdata", ReadDataW,           32'h0);
        check("sh_rsrc",  {31'd0, ResultSrcW}, 32'h0);

        // SB 0x201 and SW 0x204
        drive(1, 0, 1, 0, 3'b000, 5'd0, 32'h201, 32'h0000005A, 32'h14);
        #3;
        check("sb_be",    {28'd0, dmem_be}, 32'h2);
        check("sb_wdata", dmem_wdata,       32'h5A5A5A5A);
        step();
        drive(1, 0, 1, 0, 3'b010, 5'd0, 32'h204, 32'hCAFEF00D, 32'h18);
        #3;
        check("sw_be",    {28'd0, dmem_be}, 32'hF);
        check("sw_wdata", dmem_wdata,       32'hCAFEF00D);
        check("sw_addr",  dmem_addr,        32'h204);
        step();

        // Misaligned LW 0x101: no request, no stall, exception in W
        drive(1, 1, 0, 1, 3'b010, 5'd4, 32'h101, 32'h0, 32'h1C);
        dmem_ready = 1'b0;
        #3;
        check("mis_req",   {31'd0, dmem_req}, 32'h0);
        check("mis_stall", {31'd0, StallM},   32'h0);
        step();
        check("mis_exc",   {31'd0, ExceptW},   32'h1);
        check("mis_regw",  {31'd0, RegWriteW}, 32'h0);
        check("mis_valid", {31'd0, ValidW},    32'h1);

        // Timeout: four wait cycles then abort
        drive(1, 1, 0, 1, 3'b010, 5'd5, 32'h300, 32'h0, 32'h20);
        for (int i = 0; i < 4; i++) begin
            #3;
            check("to_stall", {31'd0, StallM}, 32'h1);
            step();
        end
        #3;
        check("to_abort_stall", {31'd0, StallM},   32'h0);
        check("to_abort_req",   {31'd0, dmem_req}, 32'h0);
        step();
        check("to_buserr", {31'd0, BusErrW},   32'h1);
        check("to_regw",   {31'd0, RegWriteW}, 32'h0);
        check("to_valid",  {31'd0, ValidW},    32'h1);

        // After abort the FSM is idle again: one wait then completion
        drive(1, 1, 0, 1, 3'b010, 5'd6, 32'h104, 32'h0, 32'h24);
        #3;
        check("post_to_stall", {31'd0, StallM}, 32'h1);
        step();
        dmem_ready = 1'b1;
        dmem_rdata = 32'h11223344;
        step();
        check("post_to_data",   ReadDataW,        32'h11223344);
        check("post_to_buserr", {31'd0, BusErrW}, 32'h0);

        // Async reset in the middle of a wait
        drive(1, 1, 0, 1, 3'b010, 5'd7, 32'h400, 32'h0, 32'h28);
        dmem_ready = 1'b0;
        #3;
        check("rw_stall", {31'd0, StallM}, 32'h1);
        step();
        #2;
        rst = 1'b0;
        #1;
        check("rw_req",    {31'd0, dmem_req}, 32'h0);
        check("rw_stall0", {31'd0, StallM},   32'h0);
        check("rw_validw", {31'd0, ValidW},   32'h0);
        drive(1, 1, 0, 0, 3'b000, 5'd9, 32'h55, 32'h0, 32'h2C);
        #1;
        rst = 1'b1;
        step();
        check("add_alu",   ALU_ResultW,         32'h55);
        check("add_regw",  {31'd0, RegWriteW},  32'h1);
        check("add_rsrc",  {31'd0, ResultSrcW}, 32'h0);
        check("add_rdata", ReadDataW,           32'h0);
        check("add_rd",    {27'd0, RDW},        32'h9);

        // ValidM=0 bubble
        drive(0, 1, 0, 0, 3'b000, 5'd10, 32'h66, 32'h0, 32'h30);
        step();
        check("bub_valid", {31'd0, ValidW},    32'h0);
        check("bub_regw",  {31'd0, RegWriteW}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
